// File: rtl/dm_load_unit.sv
// M-stage load unit: issues a word read, stalls the pipeline while it is pending,
// then aligns/extends the result into a one-beat writeback. Optional misaligned trap: LOAD_ADEL_EN.
module dm_load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic [4:0]  ld_rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        bus_err,
    output logic        adel
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic [4:0]       rd_q, rd_d;

    logic op_ok;
    logic misalign;
    logic accept;

    assign op_ok = (ld_op <= OP_LBU);

`ifdef LOAD_ADEL_EN
    assign misalign = ((ld_op == OP_LW) && (ld_addr[1:0] != 2'b00)) ||
                      (((ld_op == OP_LH) || (ld_op == OP_LHU)) && ld_addr[0]);
    assign adel     = (state_q == S_IDLE) && ld_valid && op_ok && misalign;
`else
    assign misalign = 1'b0;
    assign adel     = 1'b0;
`endif

    assign accept = (state_q == S_IDLE) && ld_valid && op_ok && !misalign;
    assign stall  = accept || (state_q == S_WAIT);

    // Without the trap, misaligned halves/words simply drop the low offset bits here.
    function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [15:0] half;
        logic [7:0]  byt;
        logic [31:0] res;
        half = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    byt = rdata[7:0];
            2'd1:    byt = rdata[15:8];
            2'd2:    byt = rdata[23:16];
            default: byt = rdata[31:24];
        endcase
        case (op)
            OP_LW:   res = rdata;
            OP_LH:   res = {{16{half[15]}}, half};
            OP_LHU:  res = {16'h0000, half};
            OP_LB:   res = {{24{byt[7]}}, byt};
            OP_LBU:  res = {24'h000000, byt};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        bus_err_d  = 1'b0;
        cnt_d      = cnt_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_d       = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = ld_op;
                    off_d      = ld_addr[1:0];
                    rd_d       = ld_rd;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {ld_addr[31:2], 2'b00};
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    wb_data_d  = extend_load(op_q, off_q, mem_rdata);
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_data_d  = 32'h0;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'h0;
            wb_rd_q    <= 5'd0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
            op_q       <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: per-cycle compare against a transaction-level load model,
// plus directed loads with literal expectations.
module tb_dm_load_unit;

    localparam int TO = 15;
`ifdef LOAD_ADEL_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [2:0]  ld_op;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        bus_err;
    logic        adel;

    dm_load_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr), .ld_rd(ld_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .bus_err(bus_err), .adel(adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          in_flight, cooldown;
    int          waited;
    logic [2:0]  m_op;
    logic [31:0] m_addr;
    logic [4:0]  m_rd;
    logic        e_req, e_wbv, e_err;
    logic [31:0] e_addr, e_data;
    logic [4:0]  e_rd;

    function automatic bit misaligned(input logic [2:0] op, input logic [31:0] a);
        return (op == 3'd0 && (a % 4) != 0) || ((op == 3'd1 || op == 3'd2) && (a % 2) != 0);
    endfunction

    function automatic bit legal(input logic [2:0] op, input logic [31:0] a);
        return (op <= 3'd4) && !(ADEL_EN && misaligned(op, a));
    endfunction

    function automatic logic [31:0] load_result(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] v;
        int sh;
        v = 32'h0;
        if (op == 3'd0) v = rdata;
        else if (op == 3'd1 || op == 3'd2) begin
            sh = int'(a & 32'd2) * 8;
            v  = (rdata >> sh) & 32'hFFFF;
            if (op == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
        end else if (op == 3'd3 || op == 3'd4) begin
            sh = int'(a % 4) * 8;
            v  = (rdata >> sh) & 32'hFF;
            if (op == 3'd3 && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    task automatic model_reset();
        in_flight = 0; cooldown = 0; waited = 0;
        m_op = 0; m_addr = 0; m_rd = 0;
        e_req = 0; e_wbv = 0; e_err = 0; e_addr = 0; e_data = 0; e_rd = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            e_wbv = 0;
            e_err = 0;
            if (in_flight) begin
                if (mem_ack) begin
                    e_data = load_result(m_op, m_addr, mem_rdata);
                    e_rd = m_rd; e_wbv = 1; e_req = 0; in_flight = 0; cooldown = 1;
                end else if (waited == TO - 1) begin
                    e_data = 0; e_rd = m_rd; e_wbv = 1; e_err = 1; e_req = 0;
                    in_flight = 0; cooldown = 1;
                end else begin
                    waited++;
                end
            end else if (cooldown) begin
                cooldown = 0;
            end else if (ld_valid && legal(ld_op, ld_addr)) begin
                in_flight = 1; waited = 0;
                m_op = ld_op; m_addr = ld_addr; m_rd = ld_rd;
                e_req = 1; e_addr = ld_addr & ~32'd3;
            end
        end
    endtask

    initial begin : compare_proc
        logic e_stall, e_adel;
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            if (reset) model_reset();
            e_stall = in_flight || (!cooldown && ld_valid && legal(ld_op, ld_addr));
            e_adel  = ADEL_EN && !in_flight && !cooldown && ld_valid && (ld_op <= 3'd4)
                      && misaligned(ld_op, ld_addr);
            chk("mem_req",  mem_req,  e_req);
            chk("mem_addr", mem_addr, e_addr);
            chk("stall",    stall,    e_stall);
            chk("wb_valid", wb_valid, e_wbv);
            chk("bus_err",  bus_err,  e_err);
            chk("adel",     adel,     e_adel);
            if (e_wbv || reset) chk("wb_data", wb_data, e_data);
            if ((e_wbv && !e_err) || reset) chk("wb_rd", wb_rd, e_rd);
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    // ack_cycle: which WAIT cycle (1-based) carries mem_ack; 0 = never.
    task automatic run_load(input logic [2:0] op, input logic [31:0] a, input logic [4:0] rd,
                            input logic [31:0] rdata, input int ack_cycle,
                            output int n_stall, output logic [31:0] g_data, output logic g_err,
                            output logic [4:0] g_rd, output logic [31:0] g_addr, output int g_cyc);
        bit done;
        done = 0; n_stall = 0; g_data = 0; g_err = 0; g_rd = 0; g_addr = 0; g_cyc = 0;
        @(negedge clk);
        ld_valid = 1; ld_op = op; ld_addr = a; ld_rd = rd; mem_rdata = rdata;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack = (ack_cycle != 0) && (c == ack_cycle);
            #3;
            if (c == 1) g_addr = mem_addr;
            if (stall) n_stall++;
            if (wb_valid) begin
                g_data = wb_data; g_err = bus_err; g_rd = wb_rd; g_cyc = cyc;
                done = 1;
                break;
            end
        end
        mem_ack = 0;
        chk("wb_seen", done, 1);
    endtask

    initial begin : stim
        int          ns, wbc[3], seen;
        logic [31:0] d, ad;
        logic        er;
        logic [4:0]  r;

        reset = 1; ld_valid = 0; ld_op = 0; ld_addr = 0; ld_rd = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk); reset = 0;

        // lb 0x103, ack on second WAIT cycle
        run_load(3'd3, 32'h0000_0103, 5'd7, 32'h80FF_1234, 2, ns, d, er, r, ad, wbc[0]);
        chk("lb_addr", ad, 32'h0000_0100);
        chk("lb_stall_cycles", ns, 3);
        chk("lb_data", d, 32'hFFFF_FF80);
        chk("lb_rd", r, 5'd7);
        chk("lb_err", er, 0);
        @(negedge clk); ld_valid = 0; #3;
        chk("lb_pulse_one_cycle", wb_valid, 0);

        run_load(3'd2, 32'h0000_0202, 5'd3, 32'h9ABC_5678, 1, ns, d, er, r, ad, wbc[0]);
        chk("lhu_data", d, 32'h0000_9ABC);
        chk("lhu_stall_cycles", ns, 2);
        run_load(3'd1, 32'h0000_0202, 5'd4, 32'h9ABC_5678, 1, ns, d, er, r, ad, wbc[0]);
        chk("lh_data", d, 32'hFFFF_9ABC);
        run_load(3'd4, 32'h0000_0011, 5'd5, 32'h1234_F0A5, 1, ns, d, er, r, ad, wbc[0]);
        chk("lbu_data", d, 32'h0000_00F0);

        // no ack: timeout
        run_load(3'd0, 32'h0000_0400, 5'd9, 32'h5555_AAAA, 0, ns, d, er, r, ad, wbc[0]);
        chk("to_stall_cycles", ns, TO + 1);
        chk("to_err", er, 1);
        chk("to_data", d, 0);
        @(negedge clk); ld_valid = 0; #3;
        chk("to_req_low", mem_req, 0);
        chk("to_stall_low", stall, 0);

        // reset while waiting, then ack pulses
        @(negedge clk); ld_valid = 1; ld_op = 0; ld_addr = 32'h40; ld_rd = 5'd11; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        @(negedge clk); reset = 1; ld_valid = 0; #3;
        chk("rstw_req", mem_req, 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_stall", stall, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = (i < 2);
            reset   = (i == 0);
            #3;
            seen += int'(wb_valid);
        end
        mem_ack = 0;
        chk("rstw_no_wb", seen, 0);

        // three back-to-back lw, zero-wait ack
        for (int i = 0; i < 3; i++) begin
            run_load(3'd0, 32'h0000_0300 + 32'(4 * i), 5'(i + 1), 32'hA000_0001 + 32'(i),
                     1, ns, d, er, r, ad, wbc[i]);
            chk("b2b_data", d, 32'hA000_0001 + 32'(i));
        end
        chk("b2b_gap01", wbc[1] - wbc[0], 3);
        chk("b2b_gap12", wbc[2] - wbc[1], 3);
        @(negedge clk); ld_valid = 0;

        // invalid op
        @(negedge clk); ld_valid = 1; ld_op = 3'd7; ld_addr = 32'h500; #3;
        chk("inv_stall", stall, 0);
        @(negedge clk); #3;
        chk("inv_req", mem_req, 0);
        @(negedge clk); ld_valid = 0;

`ifdef LOAD_ADEL_EN
        @(negedge clk); ld_valid = 1; ld_op = 3'd0; ld_addr = 32'h2; ld_rd = 5'd4; #3;
        chk("adel_flag", adel, 1);
        chk("adel_stall", stall, 0);
        @(negedge clk); #3;
        chk("adel_req", mem_req, 0);
        chk("adel_wbv", wb_valid, 0);
        @(negedge clk); ld_valid = 0;
`else
        run_load(3'd0, 32'h0000_0002, 5'd4, 32'hCAFE_F00D, 1, ns, d, er, r, ad, wbc[0]);
        chk("mis_lw_addr", ad, 32'h0000_0000);
        chk("mis_lw_data", d, 32'hCAFE_F00D);
        @(negedge clk); ld_valid = 0;
`endif

        repeat (3) @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
